// File: rtl/ptmch_spi_seq.sv
// SPI_CLK-domain frame sequencer: splits a flash frame into instruction,
// address and page-program data phases with held fields and a byte toggle.
module ptmch_spi_seq #(
  parameter int unsigned P_ADDR_BYTES = 3,
  parameter int unsigned P_MAX_DATA   = 256
) (
  input  logic                      SPI_CLK,
  input  logic                      c_spi_reset_n,
  input  logic                      SPI_MOSI,
  output logic [7:0]                INST_CODE,
  output logic                      INST_VLD,
  output logic [2:0]                CMD_CLASS,
  output logic [8*P_ADDR_BYTES-1:0] ADDR,
  output logic                      ADDR_VLD,
  output logic [7:0]                DATA_BYTE,
  output logic                      DATA_TGL,
  output logic [8:0]                BYTE_CNT,
  output logic                      OVF,
  output logic [1:0]                PHASE
);

  localparam int unsigned AW = 8 * P_ADDR_BYTES;
  localparam logic [8:0]  MAX_C  = 9'(P_MAX_DATA);
  localparam logic [2:0]  LAST_A = 3'(P_ADDR_BYTES - 1);

  typedef enum logic [1:0] {
    S_INST = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_IGN  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_PP   = 3'd1,
    C_READ = 3'd2,
    C_WREN = 3'd3,
    C_WRDI = 3'd4,
    C_RDSR = 3'd5,
    C_SE   = 3'd6,
    C_BE   = 3'd7
  } cls_t;

  function automatic cls_t decode(input logic [7:0] op);
    cls_t c;
    unique case (op)
      8'h02:   c = C_PP;
      8'h03:   c = C_READ;
      8'h06:   c = C_WREN;
      8'h04:   c = C_WRDI;
      8'h05:   c = C_RDSR;
      8'h20:   c = C_SE;
      8'hD8:   c = C_BE;
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      bc_q, bc_d;
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      acnt_q, acnt_d;
  logic [7:0]      inst_q, inst_d;
  logic            ivld_q, ivld_d;
  cls_t            cls_q, cls_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            avld_q, avld_d;
  logic [7:0]      dbyte_q, dbyte_d;
  logic            tgl_q, tgl_d;
  logic [8:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            done;
  logic [7:0]      byte_w;
  cls_t            dec_w;

  assign done   = (bc_q == 3'd7);
  assign byte_w = {shift_q, SPI_MOSI};
  assign dec_w  = decode(byte_w);

  always_ff @(posedge SPI_CLK or negedge c_spi_reset_n) begin
    if (!c_spi_reset_n) begin
      state_q <= S_INST;
      bc_q    <= '0;
      shift_q <= '0;
      acnt_q  <= '0;
      inst_q  <= '0;
      ivld_q  <= 1'b0;
      cls_q   <= C_NONE;
      addr_q  <= '0;
      avld_q  <= 1'b0;
      dbyte_q <= '0;
      tgl_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      acnt_q  <= acnt_d;
      inst_q  <= inst_d;
      ivld_q  <= ivld_d;
      cls_q   <= cls_d;
      addr_q  <= addr_d;
      avld_q  <= avld_d;
      dbyte_q <= dbyte_d;
      tgl_q   <= tgl_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    shift_d = shift_q;
    acnt_d  = acnt_q;
    inst_d  = inst_q;
    ivld_d  = ivld_q;
    cls_d   = cls_q;
    addr_d  = addr_q;
    avld_d  = avld_q;
    dbyte_d = dbyte_q;
    tgl_d   = tgl_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (state_q != S_IGN) begin
      bc_d    = bc_q + 3'd1;
      shift_d = {shift_q[5:0], SPI_MOSI};
    end

    unique case (state_q)
      S_INST: begin
        if (done) begin
          inst_d = byte_w;
          ivld_d = 1'b1;
          cls_d  = dec_w;
          if (dec_w == C_PP || dec_w == C_READ ||
              dec_w == C_SE || dec_w == C_BE)
            state_d = S_ADDR;
          else
            state_d = S_IGN;
        end
      end
      S_ADDR: begin
        if (done) begin
          addr_d = {addr_q[AW-9:0], byte_w};
          acnt_d = acnt_q + 3'd1;
          if (acnt_q == LAST_A) begin
            avld_d  = 1'b1;
            state_d = (cls_q == C_PP) ? S_DATA : S_IGN;
          end
        end
      end
      S_DATA: begin
        if (done) begin
          dbyte_d = byte_w;
          tgl_d   = ~tgl_q;
          // Count saturates at a full page; extra bytes only flag overflow
          if (cnt_q < MAX_C) cnt_d = cnt_q + 9'd1;
          else               ovf_d = 1'b1;
        end
      end
      S_IGN: ;
      default: ;
    endcase
  end

  assign INST_CODE = inst_q;
  assign INST_VLD  = ivld_q;
  assign CMD_CLASS = cls_q;
  assign ADDR      = addr_q;
  assign ADDR_VLD  = avld_q;
  assign DATA_BYTE = dbyte_q;
  assign DATA_TGL  = tgl_q;
  assign BYTE_CNT  = cnt_q;
  assign OVF       = ovf_q;
  assign PHASE     = state_q;

endmodule

// File: tb/tb_ptmch_spi_seq.sv
// Directed-vector bench for ptmch_spi_seq: bytes are shifted MSB first
// and held fields are checked on the falling edge after each byte.
module tb_ptmch_spi_seq;

  logic        SPI_CLK = 1'b0;
  logic        c_spi_reset_n = 1'b0;
  logic        SPI_MOSI = 1'b0;
  logic [7:0]  INST_CODE;
  logic        INST_VLD;
  logic [2:0]  CMD_CLASS;
  logic [23:0] ADDR;
  logic        ADDR_VLD;
  logic [7:0]  DATA_BYTE;
  logic        DATA_TGL;
  logic [8:0]  BYTE_CNT;
  logic        OVF;
  logic [1:0]  PHASE;

  int n_chk = 0;
  int n_err = 0;

  always #5 SPI_CLK = ~SPI_CLK;

  ptmch_spi_seq #(.P_ADDR_BYTES(3), .P_MAX_DATA(256)) dut (
    .SPI_CLK       (SPI_CLK),
    .c_spi_reset_n (c_spi_reset_n),
    .SPI_MOSI      (SPI_MOSI),
    .INST_CODE     (INST_CODE),
    .INST_VLD      (INST_VLD),
    .CMD_CLASS     (CMD_CLASS),
    .ADDR          (ADDR),
    .ADDR_VLD      (ADDR_VLD),
    .DATA_BYTE     (DATA_BYTE),
    .DATA_TGL      (DATA_TGL),
    .BYTE_CNT      (BYTE_CNT),
    .OVF           (OVF),
    .PHASE         (PHASE)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the
  // rising edge that samples the bit.
  task automatic send_bit(input logic b);
    SPI_MOSI = b;
    @(negedge SPI_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".inst"}, {INST_CODE, 7'd0, INST_VLD, 5'd0, CMD_CLASS}, 0);
    chk({tag, ".addr"}, {7'd0, ADDR_VLD, ADDR}, 0);
    chk({tag, ".data"}, {DATA_BYTE, 7'd0, DATA_TGL, 7'd0, BYTE_CNT}, 0);
    chk({tag, ".misc"}, {29'd0, OVF, PHASE}, 0);
  endtask

  task automatic frame_start();
    @(negedge SPI_CLK);
    c_spi_reset_n = 1'b0;
    @(negedge SPI_CLK);
    c_spi_reset_n = 1'b1;
  endtask

  initial begin
    @(negedge SPI_CLK);
    @(negedge SPI_CLK);
    all_zero("reset");

    // WREN followed by one extra byte
    frame_start();
    send_byte(8'h06);
    chk("wren.code",  INST_CODE, 8'h06);
    chk("wren.vld",   INST_VLD, 1);
    chk("wren.class", CMD_CLASS, 3);
    chk("wren.phase", PHASE, 3);
    send_byte(8'hFF);
    chk("wren.avld",  ADDR_VLD, 0);
    chk("wren.tgl",   DATA_TGL, 0);
    chk("wren.hold",  INST_CODE, 8'h06);

    // PP with three data bytes
    frame_start();
    send_byte(8'h02);
    chk("pp.class", CMD_CLASS, 1);
    chk("pp.ph1",   PHASE, 1);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("pp.avld24", ADDR_VLD, 0);
    send_byte(8'h56);
    chk("pp.addr",  ADDR, 24'h123456);
    chk("pp.avld",  ADDR_VLD, 1);
    chk("pp.ph2",   PHASE, 2);
    chk("pp.cnt0",  BYTE_CNT, 0);
    send_byte(8'hA5);
    chk("pp.tgl40", DATA_TGL, 1);
    chk("pp.d0",    DATA_BYTE, 8'hA5);
    send_byte(8'h5A);
    chk("pp.tgl48", DATA_TGL, 0);
    chk("pp.d1",    DATA_BYTE, 8'h5A);
    send_byte(8'hFF);
    chk("pp.tgl56", DATA_TGL, 1);
    chk("pp.d2",    DATA_BYTE, 8'hFF);
    chk("pp.cnt",   BYTE_CNT, 3);
    chk("pp.ovf",   OVF, 0);

    // PP page overflow: 257 data bytes
    frame_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h3C);
    chk("ovf.cnt256", BYTE_CNT, 256);
    chk("ovf.pre",    OVF, 0);
    chk("ovf.tgl256", DATA_TGL, 0);
    send_byte(8'hC3);
    chk("ovf.cnt",  BYTE_CNT, 256);
    chk("ovf.flag", OVF, 1);
    chk("ovf.last", DATA_BYTE, 8'hC3);
    chk("ovf.tgl",  DATA_TGL, 1);

    // READ with dummy/response bytes ignored
    frame_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 16; i++) send_byte(8'hAA);
    chk("rd.class", CMD_CLASS, 2);
    chk("rd.addr",  ADDR, 24'h000100);
    chk("rd.avld",  ADDR_VLD, 1);
    chk("rd.phase", PHASE, 3);
    chk("rd.tgl",   DATA_TGL, 0);
    chk("rd.cnt",   BYTE_CNT, 0);

    // Reset pulse mid-address, then SE frame
    frame_start();
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("mid.vld", INST_VLD, 1);
    c_spi_reset_n = 1'b0;
    #1;
    all_zero("mid");
    @(negedge SPI_CLK);
    c_spi_reset_n = 1'b1;
    send_byte(8'h20);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    chk("se.class", CMD_CLASS, 6);
    chk("se.addr",  ADDR, 24'hABCDEF);
    chk("se.phase", PHASE, 3);
    chk("se.avld",  ADDR_VLD, 1);

    // Unknown opcode
    frame_start();
    send_byte(8'h9F);
    chk("unk.code",  INST_CODE, 8'h9F);
    chk("unk.class", CMD_CLASS, 0);
    chk("unk.phase", PHASE, 3);

    // Truncated frame: five bits only
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("trunc.vld",   INST_VLD, 0);
    chk("trunc.phase", PHASE, 0);
    chk("trunc.code",  INST_CODE, 0);
    frame_start();
    all_zero("post");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ptmch_spi_seq.md
Name: ptmch_spi_seq

Overview:
SPI_CLK-domain frame sequencer for the pattern-match/trigger path. It parses each SPI flash frame into instruction, address and data phases, and classifies the instruction. It presents stable, held fields plus toggle-style byte events, so the CLK160M-side trigger logic can synchronise them with 2-FF stages and stability compares. Each frame starts from reset, because c_spi_reset_n is asserted by the CS-deassert edge.

Parameters:
P_ADDR_BYTES, 3, number of address bytes after an address-bearing instruction (legal: 3 or 4)
P_MAX_DATA, 256, page size in bytes; a data byte beyond this sets OVF

Ports:
SPI_CLK  in  1  SPI serial clock (mode 0; MOSI sampled on rising edge)
c_spi_reset_n  in  1  async active-low reset; asserted per frame by CS edge and by RESET_N
SPI_MOSI  in  1  serial data, MSB first
INST_CODE  out  8  captured instruction byte
INST_VLD  out  1  instruction byte complete (held)
CMD_CLASS  out  3  0=none/unknown, 1=PP(0x02), 2=READ(0x03), 3=WREN(0x06), 4=WRDI(0x04), 5=RDSR(0x05), 6=SE(0x20), 7=BE(0xD8)
ADDR  out  8*P_ADDR_BYTES  captured address, MSB first
ADDR_VLD  out  1  all address bytes complete (held)
DATA_BYTE  out  8  last completed PP data byte (held)
DATA_TGL  out  1  toggles once per completed PP data byte
BYTE_CNT  out  9  number of PP data bytes received, saturating at P_MAX_DATA
OVF  out  1  sticky; a data byte arrived with BYTE_CNT==P_MAX_DATA
PHASE  out  2  0=INST, 1=ADDR, 2=DATA, 3=IGNORE (current state)

Behaviour:
- Clock SPI_CLK. Reset c_spi_reset_n, asynchronous, active-low. All flops reset to 0: every output is 0, PHASE=INST, bit counter=0, address byte counter=0.
- 3-bit bit counter bc increments on every rising edge in INST/ADDR/DATA and wraps 7->0. A byte completes on the edge where bc==7; completed byte = {shift[6:0], SPI_MOSI}.
- INST state, on byte completion:
  - INST_CODE<=byte; INST_VLD<=1; CMD_CLASS<=decode(byte).
  - Next state: PP/READ/SE/BE -> ADDR; all other codes -> IGNORE.
  - Fields become visible after edge 8, with zero further latency.
- ADDR state, on byte completion:
  - Shift byte into ADDR LSB end; ADDR <= {ADDR, byte}.
  - Address byte counter increments. On byte P_ADDR_BYTES, ADDR_VLD<=1 (after edge 8+8*P_ADDR_BYTES).
  - Next state: PP -> DATA; READ/SE/BE -> IGNORE.
- DATA state (PP only), on byte completion:
  - DATA_BYTE<=byte; DATA_TGL<=~DATA_TGL.
  - If BYTE_CNT<P_MAX_DATA, BYTE_CNT+1; otherwise BYTE_CNT holds and OVF<=1.
  - Stays in DATA until reset.
- IGNORE: terminal. All counters and registers hold; MOSI is discarded (covers READ dummy/response bytes and the tail of WREN/RDSR frames).
- Partial bytes, i.e. CS raised mid-byte: the reset clears the partial byte. No field updates, and no toggle occurs for an incomplete byte.
- Reset mid-operation: immediate asynchronous clear of all state. There is no carry-over between frames.
- Held outputs are stable while SPI_CLK is idle. The CLK160M consumer detects new data bytes by edge on the synchronised DATA_TGL and samples DATA_BYTE once the toggle is seen.
- ADDR width is 8*P_ADDR_BYTES. With P_ADDR_BYTES=4 the address phase is 32 edges; there is no 4-byte command decoding.

Test Plan:
- WREN frame (0x06, then 8 further clocks) -> after edge 8: INST_CODE=0x06, CMD_CLASS=3, PHASE=3; ADDR_VLD=0, DATA_TGL=0 through the end of the frame.
- PP 0x02, addr 0x123456, data 0xA5,0x5A,0xFF -> ADDR=0x123456 and ADDR_VLD=1 after edge 32; DATA_TGL toggles at edges 40/48/56; DATA_BYTE=0xA5, 0x5A, 0xFF in turn; BYTE_CNT=3; OVF=0.
- PP with 257 data bytes -> BYTE_CNT=256; OVF=1 after edge 8*(4+257); DATA_BYTE=last byte.
- READ 0x03, addr 0x000100, 16 dummy bytes -> ADDR_VLD=1, PHASE=3, DATA_TGL=0, BYTE_CNT=0.
- Reset pulse at edge 13 of PP frame, then new SE frame 0x20 + addr 0xABCDEF -> all outputs 0 immediately; afterwards CMD_CLASS=6, ADDR=0xABCDEF, PHASE=3.
- Unknown opcode 0x9F and a 5-bit truncated frame -> 0x9F: CMD_CLASS=0, PHASE=3; truncated: INST_VLD stays 0.
